reg_file_2r1w: RTL and testbench

- Register file for the pipeline's decode stage: 16 registers x 16 bits, one synchronous write port, two read ports.
- It is the reader side of the register storage. The write path commits results from writeback; the read ports feed operands to decode with same-cycle write-through bypass.
- Register 0 is hardwired to zero.

---
 rtl/reg_file_2r1w_pkg.sv | 9 +
 rtl/reg_file_2r1w_if.sv | 13 +
 rtl/reg_file_2r1w_reg_word.sv | 17 +
 rtl/reg_file_2r1w.sv | 33 +++
 tb/tb_reg_file_2r1w.sv | 110 +++++++++++
 5 files changed

// File: rtl/reg_file_2r1w_pkg.sv
// reg_file_2r1w_pkg: shared sizes and types for the decode-stage register file
package reg_file_2r1w_pkg;
  localparam int DATA_W = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W = 4;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
  localparam reg_idx_t ZERO_REG = 4'd0;
endpackage

// File: rtl/reg_file_2r1w_if.sv
// reg_file_2r1w_if: read/write port bundle between pipeline and register file
interface reg_file_2r1w_if;
  import reg_file_2r1w_pkg::*;
  reg_idx_t src_reg1;
  reg_idx_t src_reg2;
  reg_idx_t dst_reg;
  logic write_reg;
  word_t dst_data;
  word_t src_data1;
  word_t src_data2;
  modport master(output src_reg1, src_reg2, dst_reg, write_reg, dst_data, input src_data1, src_data2);
  modport slave(input src_reg1, src_reg2, dst_reg, write_reg, dst_data, output src_data1, src_data2);
endinterface

// File: rtl/reg_file_2r1w_reg_word.sv
// reg_word: one storage word with write enable and async active-low clear
module reg_word
  import reg_file_2r1w_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wen_i,
  input  word_t d_i,
  output word_t q_o
);
  word_t q_q;
  // Clear on reset, otherwise capture write data when enabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else if (wen_i) q_q <= d_i;
  assign q_o = q_q;
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 16x16 register file, one write port, two bypassed read ports, r0 = 0
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  reg_file_2r1w_if.slave bus
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:1] wen;
  assign regs[0] = '0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_word
    reg_word u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .wen_i (wen[i]),
      .d_i   (bus.dst_data),
      .q_o   (regs[i])
    );
  end
  // One-hot write decode; r0 has no storage so dst_reg=0 never enables anything
  always_comb begin
    wen = '0;
    for (int k = 1; k < NUM_REGS; k++) wen[k] = bus.write_reg && (bus.dst_reg == reg_idx_t'(k));
  end
  // Read muxes: r0 and reset force zero, then same-cycle write bypass, then storage
  always_comb begin
    bus.src_data1 = (bus.src_reg1 == ZERO_REG || !rst_n) ? '0 :
                    (bus.write_reg && bus.dst_reg == bus.src_reg1) ? bus.dst_data : regs[bus.src_reg1];
    bus.src_data2 = (bus.src_reg2 == ZERO_REG || !rst_n) ? '0 :
                    (bus.write_reg && bus.dst_reg == bus.src_reg2) ? bus.dst_data : regs[bus.src_reg2];
  end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed plan plus randomized traffic against an array model
module tb_reg_file_2r1w;
  import reg_file_2r1w_pkg::*;
  timeunit 1ns;
  timeprecision 100ps;
  logic clk = 0;
  logic rst_n = 1;
  int checks = 0;
  int failures = 0;
  bit checking = 0;
  word_t mdl [NUM_REGS];
  reg_file_2r1w_if bus();
  reg_file_2r1w dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", n, $time, act, exp);
    end
  endtask
  function automatic word_t expect_rd(input reg_idx_t idx);
    if (idx == 0 || !rst_n) return '0;
    if (bus.write_reg && bus.dst_reg == idx) return bus.dst_data;
    return mdl[idx];
  endfunction
  task automatic clear_model();
    foreach (mdl[k]) mdl[k] = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst_n && bus.write_reg && bus.dst_reg != 0) mdl[bus.dst_reg] = bus.dst_data;
    #1;
  endtask
  task automatic drive(input logic w, input reg_idx_t d, input word_t dd, input reg_idx_t s1, input reg_idx_t s2);
    bus.write_reg = w; bus.dst_reg = d; bus.dst_data = dd; bus.src_reg1 = s1; bus.src_reg2 = s2;
  endtask
  always @(negedge clk)
    if (checking) begin
      chk("model_rd1", bus.src_data1, expect_rd(bus.src_reg1));
      chk("model_rd2", bus.src_data2, expect_rd(bus.src_reg2));
    end
  initial begin
    drive(0, 0, 0, 0, 0);
    #3 rst_n = 0;
    clear_model();
    checking = 1;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.src_reg1 = reg_idx_t'(i);
      bus.src_reg2 = reg_idx_t'(15 - i);
      #0.1;
      chk("reset_rd1", bus.src_data1, 16'h0000);
      chk("reset_rd2", bus.src_data2, 16'h0000);
    end
    tick();
    rst_n = 1;
    drive(1, 3, 16'hBEEF, 0, 0);
    tick();
    drive(1, 15, 16'h1234, 0, 0);
    tick();
    drive(0, 0, 0, 3, 15);
    #1 chk("wr_reg3", bus.src_data1, 16'hBEEF);
    chk("wr_reg15", bus.src_data2, 16'h1234);
    drive(1, 5, 16'h0001, 0, 0);
    tick();
    drive(1, 5, 16'hA5A5, 5, 5);
    #1 chk("byp_rd1", bus.src_data1, 16'hA5A5);
    chk("byp_rd2", bus.src_data2, 16'hA5A5);
    tick();
    bus.write_reg = 0;
    #1 chk("post_byp_rd1", bus.src_data1, 16'hA5A5);
    chk("post_byp_rd2", bus.src_data2, 16'hA5A5);
    drive(1, 0, 16'hFFFF, 0, 0);
    #1 chk("zero_byp", bus.src_data1, 16'h0000);
    tick();
    bus.write_reg = 0;
    #1 chk("zero_after", bus.src_data1, 16'h0000);
    drive(0, 7, 16'h5555, 0, 7);
    #1 chk("nowr_before", bus.src_data2, 16'h0000);
    tick();
    #1 chk("nowr_after", bus.src_data2, 16'h0000);
    drive(1, 9, 16'h00FF, 9, 0);
    tick();
    drive(0, 0, 0, 9, 0);
    #1 chk("reg9_set", bus.src_data1, 16'h00FF);
    drive(1, 9, 16'h7777, 9, 0);
    rst_n = 0;
    clear_model();
    tick();
    rst_n = 1;
    drive(0, 0, 0, 9, 9);
    #1 chk("rst_wr_rd1", bus.src_data1, 16'h0000);
    chk("rst_wr_rd2", bus.src_data2, 16'h0000);
    tick();
    for (int n = 0; n < 600; n++) begin
      automatic reg_idx_t d = reg_idx_t'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 3) != 0), d, word_t'($urandom),
            ($urandom_range(0, 3) == 0) ? d : reg_idx_t'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? d : reg_idx_t'($urandom_range(0, 15)));
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 0;
        clear_model();
      end else rst_n = 1;
      tick();
    end
    checking = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
